// File: rtl/vga_scaled_display.sv
// VGA raster generator and frame-buffer reader: sync timing, 1x/2x image replication,
// test patterns, border colour, and a flag pipeline matched to the RAM read latency.
module vga_scaled_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int SCALE    = 2,
  parameter int ADDR_W   = 17,
  parameter int RAM_LAT  = 1,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              clk25,
  input  logic              reset,
  input  logic [11:0]       ram_output_data,
  input  logic              ready_display,
  input  logic [1:0]        pattern_mode,
  input  logic [11:0]       border_color,
  output logic [ADDR_W-1:0] read_RAM_address,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start,
  output logic              active_video
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int SH      = (SCALE == 2) ? 1 : 0;
  localparam int PD      = 1 + RAM_LAT;
  localparam int XW      = (HCW > 8) ? HCW : 8;
  localparam int YW      = (VCW > 5) ? VCW : 5;

  localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_END = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_START  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END    = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] WIN_W     = HCW'(IMG_W * SCALE);
  localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_END = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_START  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END    = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] WIN_H     = VCW'(IMG_H * SCALE);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic       win;
    logic       fs;
    logic [7:0] x;
    logic [4:0] y;
  } pix_t;

  logic [HCW-1:0]    r_hcount;
  logic [VCW-1:0]    r_vcount;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_mode;
  logic              r_ready;
  pix_t              r_pipe [PD];
  logic [11:0]       r_rgb;
  logic              r_hs;
  logic              r_vs;
  logic              r_fs;
  logic              r_av;

  logic              w_h_last;
  logic              w_v_last;
  logic              w_v_in_win;
  logic              w_in_win;
  logic              w_last_rep;
  logic [HCW-1:0]    w_x;
  logic [XW-1:0]     w_x_ext;
  logic [YW-1:0]     w_y_ext;
  pix_t              w_s0;
  pix_t              w_p;
  logic [11:0]       w_rgb;
  logic              w_unused;

  assign w_h_last   = (r_hcount == H_LAST);
  assign w_v_last   = (r_vcount == V_LAST);
  assign w_v_in_win = (r_vcount < WIN_H);
  assign w_in_win   = w_v_in_win && (r_hcount < WIN_W);
  assign w_last_rep = (SCALE == 1) ? 1'b1 : r_vcount[0];
  assign w_x        = r_hcount >> SH;
  assign w_x_ext    = XW'(w_x);
  assign w_y_ext    = YW'(r_vcount >> SH);
  assign w_unused   = ^{w_x_ext, w_y_ext};

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_h_last) begin
      r_hcount <= '0;
      r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  // line_base steps once per source line, i.e. after the last replicated copy.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      r_line_base <= '0;
    end else if (w_h_last) begin
      if (w_v_last)
        r_line_base <= '0;
      else if (w_v_in_win && w_last_rep)
        r_line_base <= r_line_base + ADDR_W'(IMG_W);
    end
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset)
      r_addr <= '0;
    else if (!w_v_in_win)
      r_addr <= '0;
    else if (w_in_win)
      r_addr <= r_line_base + ADDR_W'(w_x);
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      r_mode  <= 2'd0;
      r_ready <= 1'b0;
    end else if (r_hcount == '0 && r_vcount == '0) begin
      r_mode  <= pattern_mode;
      r_ready <= ready_display;
    end
  end

  always_comb begin
    w_s0     = '0;
    w_s0.hs  = (r_hcount >= HS_START) && (r_hcount < HS_END);
    w_s0.vs  = (r_vcount >= VS_START) && (r_vcount < VS_END);
    w_s0.act = (r_hcount < H_ACT_END) && (r_vcount < V_ACT_END);
    w_s0.win = w_in_win;
    w_s0.fs  = (r_hcount == '0) && (r_vcount == '0);
    w_s0.x   = w_x_ext[7:0];
    w_s0.y   = w_y_ext[4:0];
  end

  // Flags travel PD stages so the last one lines up with ram_output_data.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PD; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_s0;
      for (int i = 1; i < PD; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_p = r_pipe[PD-1];

  always_comb begin
    w_rgb = 12'h000;
    if (w_p.act) begin
      if (!w_p.win) begin
        w_rgb = border_color;
      end else begin
        case (r_mode)
          2'd0:    w_rgb = r_ready ? ram_output_data : 12'h000;
          2'd1:    w_rgb = 12'h777;
          2'd2:    w_rgb = {w_p.x[3:0], w_p.y[3:0], w_p.x[7:4]};
          default: w_rgb = (w_p.x[4] ^ w_p.y[4]) ? 12'hFFF : 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      r_rgb <= 12'h000;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_fs  <= 1'b0;
      r_av  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= w_p.hs ? HS_POL : ~HS_POL;
      r_vs  <= w_p.vs ? VS_POL : ~VS_POL;
      r_fs  <= w_p.fs;
      r_av  <= w_p.act;
    end
  end

  assign read_RAM_address = r_addr;
  assign vga_red          = r_rgb[11:8];
  assign vga_green        = r_rgb[7:4];
  assign vga_blue         = r_rgb[3:0];
  assign vga_hsync        = r_hs;
  assign vga_vsync        = r_vs;
  assign frame_start      = r_fs;
  assign active_video     = r_av;

endmodule

// File: tb/tb_vga_scaled_display.sv
// Directed bench for vga_scaled_display on a reduced 96x26 raster: instance A uses 2x
// replication with RAM_LAT=1, instance B uses 1x with RAM_LAT=2.
module tb_vga_scaled_display;

  logic        clk25;
  logic        rst_n;
  logic [1:0]  mode_a;
  logic        rdy_a;
  logic [11:0] ram_a;
  logic [11:0] ram_b;
  logic [11:0] ram_b1;
  logic [8:0]  addr_a, addr_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, fs_a, av_a, hs_b, vs_b, fs_b, av_b;

  int cyc;
  int n_vec;
  int n_err;

  typedef struct {
    int          n;
    bit          drv;
    bit          dut_b;
    logic [1:0]  mode;
    logic        rdy;
    logic [8:0]  addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        av;
  } vec_t;

  vec_t tbl[$];

  vga_scaled_display #(
    .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(36), .IMG_H(8), .SCALE(2), .ADDR_W(9), .RAM_LAT(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .clk25(clk25), .reset(rst_n), .ram_output_data(ram_a),
    .ready_display(rdy_a), .pattern_mode(mode_a), .border_color(12'hABC),
    .read_RAM_address(addr_a), .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .frame_start(fs_a), .active_video(av_a)
  );

  vga_scaled_display #(
    .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(36), .IMG_H(8), .SCALE(1), .ADDR_W(9), .RAM_LAT(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk25(clk25), .reset(rst_n), .ram_output_data(ram_b),
    .ready_display(1'b1), .pattern_mode(2'd0), .border_color(12'hF00),
    .read_RAM_address(addr_b), .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .frame_start(fs_b), .active_video(av_b)
  );

  // Clock and reset-relative cycle counter
  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // RAM models: data equals the address, delayed by each instance's latency
  always @(posedge clk25) begin
    ram_a  <= {3'b000, addr_a};
    ram_b1 <= {3'b000, addr_b};
    ram_b  <= ram_b1;
  end

  function automatic vec_t chk(input bit b, input int n, input logic [8:0] a,
                               input logic [11:0] rgb, input logic hs, input logic vs,
                               input logic fs, input logic av);
    vec_t v;
    v = '{n: n, drv: 1'b0, dut_b: b, mode: 2'd0, rdy: 1'b0, addr: a, rgb: rgb,
          hs: hs, vs: vs, fs: fs, av: av};
    return v;
  endfunction

  function automatic vec_t drv(input int n, input logic [1:0] m, input logic r);
    vec_t v;
    v = '{n: n, drv: 1'b1, dut_b: 1'b0, mode: m, rdy: r, addr: '0, rgb: '0,
          hs: 1'b0, vs: 1'b0, fs: 1'b0, av: 1'b0};
    return v;
  endfunction

  task automatic wait_cycle(input int n);
    int guard;
    guard = 0;
    if (cyc > n) begin
      n_vec++;
      n_err++;
      $display("FAIL order: at cycle %0d, required cycle %0d", cyc, n);
    end
    while (cyc < n && guard < 30000) begin
      @(negedge clk25);
      guard++;
    end
    if (cyc < n) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: at cycle %0d, required cycle %0d", cyc, n);
    end
    #1;
  endtask

  task automatic check_vec(input vec_t v);
    logic [8:0]  ga;
    logic [11:0] grgb;
    logic        ghs, gvs, gfs, gav;
    if (v.dut_b) begin
      ga = addr_b; grgb = {r_b, g_b, b_b}; ghs = hs_b; gvs = vs_b; gfs = fs_b; gav = av_b;
    end else begin
      ga = addr_a; grgb = {r_a, g_a, b_a}; ghs = hs_a; gvs = vs_a; gfs = fs_a; gav = av_a;
    end
    n_vec++;
    if (ga !== v.addr || grgb !== v.rgb || ghs !== v.hs || gvs !== v.vs ||
        gfs !== v.fs || gav !== v.av) begin
      n_err++;
      $display("FAIL dut_%s n=%0d (got/want): addr %h/%h rgb %h/%h hs %b/%b vs %b/%b fs %b/%b av %b/%b",
               v.dut_b ? "b" : "a", v.n, ga, v.addr, grgb, v.rgb, ghs, v.hs, gvs, v.vs,
               gfs, v.fs, gav, v.av);
    end
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    mode_a = 2'd0;
    rdy_a  = 1'b1;

    // First frame, mode 0 with ready: reset state, latency, addresses, sync, border
    tbl.push_back(chk(0,    0, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,    2, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,    3, 9'h001, 12'h000, 1, 1, 1, 1));
    tbl.push_back(chk(1,    3, 9'h002, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,    4, 9'h001, 12'h000, 1, 1, 0, 1));
    tbl.push_back(chk(1,    4, 9'h003, 12'h000, 1, 1, 1, 1));
    tbl.push_back(chk(0,    8, 9'h003, 12'h002, 1, 1, 0, 1));
    tbl.push_back(chk(1,   39, 9'h023, 12'h023, 1, 1, 0, 1));
    tbl.push_back(chk(1,   40, 9'h023, 12'hF00, 1, 1, 0, 1));
    tbl.push_back(chk(0,   74, 9'h023, 12'h023, 1, 1, 0, 1));
    tbl.push_back(chk(0,   75, 9'h023, 12'hABC, 1, 1, 0, 1));
    tbl.push_back(chk(1,   83, 9'h023, 12'hF00, 1, 1, 0, 1));
    tbl.push_back(chk(1,   84, 9'h023, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,   86, 9'h023, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,   87, 9'h023, 12'h000, 0, 1, 0, 0));
    tbl.push_back(chk(1,   88, 9'h023, 12'h000, 0, 1, 0, 0));
    tbl.push_back(chk(0,   94, 9'h023, 12'h000, 0, 1, 0, 0));
    tbl.push_back(chk(0,   95, 9'h023, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,   97, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0,   99, 9'h001, 12'h000, 1, 1, 0, 1));
    tbl.push_back(chk(1,  105, 9'h02C, 12'h029, 1, 1, 0, 1));
    tbl.push_back(chk(0,  195, 9'h025, 12'h024, 1, 1, 0, 1));
    tbl.push_back(chk(1,  711, 9'h11F, 12'h11F, 1, 1, 0, 1));
    tbl.push_back(chk(1,  782, 9'h000, 12'hF00, 1, 1, 0, 1));
    tbl.push_back(chk(0, 1512, 9'h11F, 12'h11E, 1, 1, 0, 1));
    tbl.push_back(chk(0, 1514, 9'h11F, 12'h11F, 1, 1, 0, 1));
    tbl.push_back(chk(0, 1537, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0, 1539, 9'h000, 12'hABC, 1, 1, 0, 1));
    tbl.push_back(chk(1, 1929, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0, 2114, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0, 2115, 9'h000, 12'h000, 1, 0, 0, 0));
    tbl.push_back(chk(0, 2306, 9'h000, 12'h000, 1, 0, 0, 0));
    tbl.push_back(chk(0, 2307, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0, 2498, 9'h000, 12'h000, 1, 1, 0, 0));
    tbl.push_back(chk(0, 2499, 9'h001, 12'h000, 1, 1, 1, 1));
    tbl.push_back(chk(1, 2500, 9'h003, 12'h000, 1, 1, 1, 1));
    tbl.push_back(chk(0, 2501, 9'h002, 12'h001, 1, 1, 0, 1));
    // Mid-frame mode change is held off until the next frame start
    tbl.push_back(drv(2980, 2'd3, 1'b1));
    tbl.push_back(chk(0, 3085, 9'h072, 12'h071, 1, 1, 0, 1));
    tbl.push_back(chk(0, 5026, 9'h010, 12'h000, 1, 1, 0, 1));
    tbl.push_back(chk(0, 5027, 9'h011, 12'hFFF, 1, 1, 0, 1));
    tbl.push_back(chk(0, 5059, 9'h021, 12'h000, 1, 1, 0, 1));
    tbl.push_back(chk(0, 5067, 9'h023, 12'hABC, 1, 1, 0, 1));
    tbl.push_back(drv(5500, 2'd2, 1'b1));
    tbl.push_back(chk(0, 8008, 9'h05B, 12'h221, 1, 1, 0, 1));
    tbl.push_back(drv(8500, 2'd1, 1'b0));
    tbl.push_back(chk(0, 10275, 9'h025, 12'h777, 1, 1, 0, 1));
    tbl.push_back(drv(11000, 2'd0, 1'b0));
    tbl.push_back(chk(0, 12493, 9'h006, 12'h000, 1, 1, 0, 1));
    tbl.push_back(chk(0, 12558, 9'h023, 12'hABC, 1, 1, 0, 1));
    tbl.push_back(drv(12800, 2'd0, 1'b1));
    tbl.push_back(chk(0, 13069, 9'h072, 12'h000, 1, 1, 0, 1));

    repeat (4) @(negedge clk25);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      wait_cycle(tbl[i].n);
      if (tbl[i].drv) begin
        mode_a = tbl[i].mode;
        rdy_a  = tbl[i].rdy;
      end else begin
        check_vec(tbl[i]);
      end
    end

    // Reset mid-line (frame 6, line 5, hcount 41): immediate return to reset values
    wait_cycle(15500);
    check_vec(chk(0, 15500, 9'h05D, 12'h05C, 1, 1, 0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check_vec(chk(0, 0, 9'h000, 12'h000, 1, 1, 0, 0));
    check_vec(chk(1, 0, 9'h000, 12'h000, 1, 1, 0, 0));
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;

    // After release the raster restarts at (0,0): replay the opening line
    foreach (tbl[i]) begin
      if (!tbl[i].drv && tbl[i].n <= 99) begin
        wait_cycle(tbl[i].n);
        check_vec(tbl[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
